// File: rtl/axi4_aw_xlate_sender.sv
// -----------------------------------------------------------------------------
// axi4_aw_xlate_sender
//
// Write-address stage behind the AW input buffer of the RAB slave port. One
// buffered AW burst is taken at a time and its address is sent for
// translation. A hit forwards the translated AW to the master port; a miss
// drops the burst and asks the B stage for a SLVERR. Each forward/drop
// decision is pushed into a small FIFO that the W stage pops to route or
// discard the matching write data.
//
// Handshakes: every valid/ready pair transfers in a cycle where both are high
// at the rising clock edge. A source keeps valid and its payload stable until
// that transfer happens; ready may change freely and never depends on valid.
//
// Ports
//   axi4_aclk, axi4_arstn       clock, asynchronous active-low reset
//   s_axi4_aw*                  AW from the input buffer (awready is an output)
//   lookup_req / lookup_addr    translation request and untranslated address
//   lookup_done / lookup_miss   single-cycle result strobe and miss qualifier
//   lookup_out_addr             translated address, valid on a hit
//   m_axi4_aw*                  translated AW to the interconnect
//   w_drop_valid / w_drop       head of the drop-decision FIFO (1 = discard)
//   w_drop_ready                W stage pops the head entry
//   b_err_valid / b_err_id      SLVERR request for a dropped burst
//   b_err_ready                 B stage accepts the error request
//   state_dbg                   current FSM state (IDLE=0, LOOKUP=1, SEND=2, DROP=3)
// -----------------------------------------------------------------------------
module axi4_aw_xlate_sender #(
    parameter int AXI_ID_WIDTH    = 4,
    parameter int AXI_USER_WIDTH  = 4,
    parameter int DROP_FIFO_DEPTH = 4
) (
    input  logic                      axi4_aclk,
    input  logic                      axi4_arstn,

    input  logic [AXI_ID_WIDTH-1:0]   s_axi4_awid,
    input  logic [31:0]               s_axi4_awaddr,
    input  logic                      s_axi4_awvalid,
    output logic                      s_axi4_awready,
    input  logic [7:0]                s_axi4_awlen,
    input  logic [2:0]                s_axi4_awsize,
    input  logic [1:0]                s_axi4_awburst,
    input  logic                      s_axi4_awlock,
    input  logic [2:0]                s_axi4_awprot,
    input  logic [3:0]                s_axi4_awcache,
    input  logic [3:0]                s_axi4_awregion,
    input  logic [3:0]                s_axi4_awqos,
    input  logic [AXI_USER_WIDTH-1:0] s_axi4_awuser,

    output logic                      lookup_req,
    output logic [31:0]               lookup_addr,
    input  logic                      lookup_done,
    input  logic                      lookup_miss,
    input  logic [31:0]               lookup_out_addr,

    output logic [AXI_ID_WIDTH-1:0]   m_axi4_awid,
    output logic [31:0]               m_axi4_awaddr,
    output logic                      m_axi4_awvalid,
    input  logic                      m_axi4_awready,
    output logic [7:0]                m_axi4_awlen,
    output logic [2:0]                m_axi4_awsize,
    output logic [1:0]                m_axi4_awburst,
    output logic                      m_axi4_awlock,
    output logic [2:0]                m_axi4_awprot,
    output logic [3:0]                m_axi4_awcache,
    output logic [3:0]                m_axi4_awregion,
    output logic [3:0]                m_axi4_awqos,
    output logic [AXI_USER_WIDTH-1:0] m_axi4_awuser,

    output logic                      w_drop_valid,
    output logic                      w_drop,
    input  logic                      w_drop_ready,

    output logic                      b_err_valid,
    output logic [AXI_ID_WIDTH-1:0]   b_err_id,
    input  logic                      b_err_ready,

    output logic [1:0]                state_dbg
);

    localparam int PTR_W = $clog2(DROP_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DROP_FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        SEND   = 2'd2,
        DROP   = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Registered AW burst; addr is overwritten with the translation on a hit.
    logic [AXI_ID_WIDTH-1:0]   aw_id;
    logic [31:0]               aw_addr;
    logic [7:0]                aw_len;
    logic [2:0]                aw_size;
    logic [1:0]                aw_burst;
    logic                      aw_lock;
    logic [2:0]                aw_prot;
    logic [3:0]                aw_cache;
    logic [3:0]                aw_region;
    logic [3:0]                aw_qos;
    logic [AXI_USER_WIDTH-1:0] aw_user;

    // Drop-decision FIFO
    logic                      fifo_mem [DROP_FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr;
    logic [PTR_W-1:0]          rd_ptr;
    logic [CNT_W-1:0]          count;

    logic accept;
    logic push;
    logic push_drop;
    logic pop;

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
        if (!axi4_arstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        s_axi4_awready = 1'b0;
        lookup_req     = 1'b0;
        m_axi4_awvalid = 1'b0;
        b_err_valid    = 1'b0;
        accept         = 1'b0;
        push           = 1'b0;
        push_drop      = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Every accept pushes exactly one decision, so gating on a
                // non-full FIFO here is what rules out overflow.
                s_axi4_awready = axi4_arstn && (count < FULL_CNT);
                if (s_axi4_awvalid && s_axi4_awready) begin
                    accept  = 1'b1;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                lookup_req = 1'b1;
                if (lookup_done) begin
                    push      = 1'b1;
                    push_drop = lookup_miss;
                    state_d   = lookup_miss ? DROP : SEND;
                end
            end
            SEND: begin
                m_axi4_awvalid = 1'b1;
                if (m_axi4_awready) begin
                    state_d = IDLE;
                end
            end
            DROP: begin
                b_err_valid = 1'b1;
                if (b_err_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign state_dbg = state_q;

    // ------------------------------------------------------------ AW register
    always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
        if (!axi4_arstn) begin
            aw_id     <= '0;
            aw_addr   <= '0;
            aw_len    <= '0;
            aw_size   <= '0;
            aw_burst  <= '0;
            aw_lock   <= 1'b0;
            aw_prot   <= '0;
            aw_cache  <= '0;
            aw_region <= '0;
            aw_qos    <= '0;
            aw_user   <= '0;
        end else if (accept) begin
            aw_id     <= s_axi4_awid;
            aw_addr   <= s_axi4_awaddr;
            aw_len    <= s_axi4_awlen;
            aw_size   <= s_axi4_awsize;
            aw_burst  <= s_axi4_awburst;
            aw_lock   <= s_axi4_awlock;
            aw_prot   <= s_axi4_awprot;
            aw_cache  <= s_axi4_awcache;
            aw_region <= s_axi4_awregion;
            aw_qos    <= s_axi4_awqos;
            aw_user   <= s_axi4_awuser;
        end else if (push && !push_drop) begin
            aw_addr   <= lookup_out_addr;
        end
    end

    assign lookup_addr     = aw_addr;

    assign m_axi4_awid     = aw_id;
    assign m_axi4_awaddr   = aw_addr;
    assign m_axi4_awlen    = aw_len;
    assign m_axi4_awsize   = aw_size;
    assign m_axi4_awburst  = aw_burst;
    assign m_axi4_awlock   = aw_lock;
    assign m_axi4_awprot   = aw_prot;
    assign m_axi4_awcache  = aw_cache;
    assign m_axi4_awregion = aw_region;
    assign m_axi4_awqos    = aw_qos;
    assign m_axi4_awuser   = aw_user;

    assign b_err_id        = aw_id;

    // -------------------------------------------------------- drop FIFO
    // A pop on an empty FIFO is dropped here, so a push into an empty FIFO
    // only becomes visible to the W stage on the following cycle.
    assign pop = w_drop_ready && (count != '0);

    always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
        if (!axi4_arstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DROP_FIFO_DEPTH; i++) begin
                fifo_mem[i] <= 1'b0;
            end
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= push_drop;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign w_drop_valid = (count != '0);
    assign w_drop       = fifo_mem[rd_ptr];

endmodule

// File: tb/tb_axi4_aw_xlate_sender.sv
// -----------------------------------------------------------------------------
// tb_axi4_aw_xlate_sender
//
// Directed bench for axi4_aw_xlate_sender. A transaction-level model (one
// burst in flight, plus a queue of pending drop decisions) predicts every
// output on each falling edge; scoreboards of expected AW addresses and error
// IDs are checked at the handshakes; literal checks pin the key cases.
// -----------------------------------------------------------------------------
module tb_axi4_aw_xlate_sender;

    localparam int IDW = 4;
    localparam int UW  = 4;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [31:0]    addr;
        logic [7:0]     len;
        logic [2:0]     size;
        logic [1:0]     burst;
        logic           lock;
        logic [2:0]     prot;
        logic [3:0]     cache;
        logic [3:0]     region;
        logic [3:0]     qos;
        logic [UW-1:0]  user;
    } aw_t;

    // ------------------------------------------------ clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------ DUT signals
    aw_t            s_aw;
    logic           s_axi4_awvalid;
    logic           s_axi4_awready;
    logic           lookup_req;
    logic [31:0]    lookup_addr;
    logic           lookup_done;
    logic           lookup_miss;
    logic [31:0]    lookup_out_addr;
    logic [IDW-1:0] m_axi4_awid;
    logic [31:0]    m_axi4_awaddr;
    logic           m_axi4_awvalid;
    logic           m_axi4_awready;
    logic [7:0]     m_axi4_awlen;
    logic [2:0]     m_axi4_awsize;
    logic [1:0]     m_axi4_awburst;
    logic           m_axi4_awlock;
    logic [2:0]     m_axi4_awprot;
    logic [3:0]     m_axi4_awcache;
    logic [3:0]     m_axi4_awregion;
    logic [3:0]     m_axi4_awqos;
    logic [UW-1:0]  m_axi4_awuser;
    logic           w_drop_valid;
    logic           w_drop;
    logic           w_drop_ready;
    logic           b_err_valid;
    logic [IDW-1:0] b_err_id;
    logic           b_err_ready;
    logic [1:0]     state_dbg;
    aw_t            m_obs;

    assign m_obs = {m_axi4_awid, m_axi4_awaddr, m_axi4_awlen, m_axi4_awsize,
                    m_axi4_awburst, m_axi4_awlock, m_axi4_awprot, m_axi4_awcache,
                    m_axi4_awregion, m_axi4_awqos, m_axi4_awuser};

    axi4_aw_xlate_sender #(
        .AXI_ID_WIDTH    (IDW),
        .AXI_USER_WIDTH  (UW),
        .DROP_FIFO_DEPTH (4)
    ) dut (
        .axi4_aclk       (clk),
        .axi4_arstn      (rst_n),
        .s_axi4_awid     (s_aw.id),
        .s_axi4_awaddr   (s_aw.addr),
        .s_axi4_awvalid  (s_axi4_awvalid),
        .s_axi4_awready  (s_axi4_awready),
        .s_axi4_awlen    (s_aw.len),
        .s_axi4_awsize   (s_aw.size),
        .s_axi4_awburst  (s_aw.burst),
        .s_axi4_awlock   (s_aw.lock),
        .s_axi4_awprot   (s_aw.prot),
        .s_axi4_awcache  (s_aw.cache),
        .s_axi4_awregion (s_aw.region),
        .s_axi4_awqos    (s_aw.qos),
        .s_axi4_awuser   (s_aw.user),
        .lookup_req      (lookup_req),
        .lookup_addr     (lookup_addr),
        .lookup_done     (lookup_done),
        .lookup_miss     (lookup_miss),
        .lookup_out_addr (lookup_out_addr),
        .m_axi4_awid     (m_axi4_awid),
        .m_axi4_awaddr   (m_axi4_awaddr),
        .m_axi4_awvalid  (m_axi4_awvalid),
        .m_axi4_awready  (m_axi4_awready),
        .m_axi4_awlen    (m_axi4_awlen),
        .m_axi4_awsize   (m_axi4_awsize),
        .m_axi4_awburst  (m_axi4_awburst),
        .m_axi4_awlock   (m_axi4_awlock),
        .m_axi4_awprot   (m_axi4_awprot),
        .m_axi4_awcache  (m_axi4_awcache),
        .m_axi4_awregion (m_axi4_awregion),
        .m_axi4_awqos    (m_axi4_awqos),
        .m_axi4_awuser   (m_axi4_awuser),
        .w_drop_valid    (w_drop_valid),
        .w_drop          (w_drop),
        .w_drop_ready    (w_drop_ready),
        .b_err_valid     (b_err_valid),
        .b_err_id        (b_err_id),
        .b_err_ready     (b_err_ready),
        .state_dbg       (state_dbg)
    );

    // ------------------------------------------------ scoreboard
    int checks = 0;
    int errors = 0;
    logic [31:0]    exp_q[$];     // expected translated addresses on m_aw
    logic [IDW-1:0] exp_b_q[$];   // expected IDs on the error request

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------ behavioural model
    // One burst at most is owned by the block: it is accepted, then waits for
    // its translation result, then waits to be sent (hit) or reported (miss).
    bit  mdl_busy;
    bit  mdl_decided;
    bit  mdl_hit;
    aw_t mdl_cur;
    bit  drop_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_busy    = 1'b0;
            mdl_decided = 1'b0;
            mdl_hit     = 1'b0;
            mdl_cur     = '0;
            drop_q.delete();
        end else begin
            int sz0;
            sz0 = drop_q.size();
            if (w_drop_ready && sz0 > 0) void'(drop_q.pop_front());
            if (!mdl_busy) begin
                if (s_axi4_awvalid && sz0 < 4) begin
                    mdl_busy    = 1'b1;
                    mdl_decided = 1'b0;
                    mdl_cur     = s_aw;
                end
            end else if (!mdl_decided) begin
                if (lookup_done) begin
                    mdl_decided = 1'b1;
                    mdl_hit     = !lookup_miss;
                    if (!lookup_miss) mdl_cur.addr = lookup_out_addr;
                    drop_q.push_back(lookup_miss);
                end
            end else if (mdl_hit) begin
                if (m_axi4_awready) begin
                    mdl_busy = 1'b0;
                    if (exp_q.size() == 0) chk("aw_sb_unexpected", 1, 0);
                    else chk("aw_sb_addr", m_axi4_awaddr, exp_q.pop_front());
                end
            end else begin
                if (b_err_ready) begin
                    mdl_busy = 1'b0;
                    if (exp_b_q.size() == 0) chk("b_sb_unexpected", 1, 0);
                    else chk("b_sb_id", b_err_id, exp_b_q.pop_front());
                end
            end
        end
    end

    // Compare process: every falling edge, all outputs against the model.
    always @(negedge clk) begin
        chk("s_awready",   s_axi4_awready, rst_n && !mdl_busy && drop_q.size() < 4);
        chk("lookup_req",  lookup_req,     mdl_busy && !mdl_decided);
        chk("m_awvalid",   m_axi4_awvalid, mdl_busy && mdl_decided && mdl_hit);
        chk("b_err_valid", b_err_valid,    mdl_busy && mdl_decided && !mdl_hit);
        chk("w_drop_valid", w_drop_valid,  drop_q.size() > 0);
        if (drop_q.size() > 0) chk("w_drop", w_drop, drop_q[0]);
        if (mdl_busy && !mdl_decided) chk("lookup_addr", lookup_addr, mdl_cur.addr);
        if (mdl_busy && mdl_decided && mdl_hit) chk("m_aw_fields", m_obs, mdl_cur);
        if (mdl_busy && mdl_decided && !mdl_hit) chk("b_err_id", b_err_id, mdl_cur.id);
        if (!rst_n) begin
            chk("rst_m_aw_fields", m_obs, 0);
            chk("rst_lookup_addr", lookup_addr, 0);
        end
    end

    // ------------------------------------------------ driver tasks
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic put_aw(input aw_t a);
        int n;
        bit hs;
        n  = 0;
        hs = 1'b0;
        s_aw = a;
        s_axi4_awvalid = 1'b1;
        while (!hs && n < 100) begin
            @(posedge clk);
            hs = s_axi4_awready;
            n++;
            #1;
        end
        s_axi4_awvalid = 1'b0;
        if (!hs) chk("aw_accept_timeout", 0, 1);
    endtask

    task automatic resolve(input bit miss, input logic [31:0] oaddr, input int delay);
        int n;
        n = 0;
        while (!lookup_req && n < 50) begin
            cyc();
            n++;
        end
        if (!lookup_req) chk("lookup_req_timeout", 0, 1);
        repeat (delay) cyc();
        lookup_done     = 1'b1;
        lookup_miss     = miss;
        lookup_out_addr = oaddr;
        cyc();
        lookup_done     = 1'b0;
        lookup_miss     = 1'b0;
    endtask

    task automatic wait_m_hs();
        int n;
        bit hs;
        n  = 0;
        hs = 1'b0;
        m_axi4_awready = 1'b1;
        while (!hs && n < 50) begin
            @(posedge clk);
            hs = m_axi4_awvalid;
            n++;
            #1;
        end
        m_axi4_awready = 1'b0;
        if (!hs) chk("m_aw_hs_timeout", 0, 1);
    endtask

    task automatic wait_b_hs();
        int n;
        bit hs;
        n  = 0;
        hs = 1'b0;
        b_err_ready = 1'b1;
        while (!hs && n < 50) begin
            @(posedge clk);
            hs = b_err_valid;
            n++;
            #1;
        end
        b_err_ready = 1'b0;
        if (!hs) chk("b_err_hs_timeout", 0, 1);
    endtask

    task automatic drain_drops();
        int n;
        n = 0;
        while (w_drop_valid && n < 10) begin
            w_drop_ready = 1'b1;
            cyc();
            n++;
        end
        w_drop_ready = 1'b0;
        chk("drain_empty", w_drop_valid, 0);
    endtask

    function automatic aw_t mk_aw(input logic [IDW-1:0] id, input logic [31:0] addr,
                                  input logic [7:0] len);
        aw_t a;
        a        = '0;
        a.id     = id;
        a.addr   = addr;
        a.len    = len;
        a.size   = 3'd2;
        a.burst  = 2'd1;
        a.lock   = 1'b1;
        a.prot   = 3'b010;
        a.cache  = 4'h3;
        a.region = 4'h1;
        a.qos    = 4'h2;
        a.user   = 4'ha;
        return a;
    endfunction

    // ------------------------------------------------ directed stimulus
    initial begin
        s_aw            = '0;
        s_axi4_awvalid  = 1'b0;
        lookup_done     = 1'b0;
        lookup_miss     = 1'b0;
        lookup_out_addr = '0;
        m_axi4_awready  = 1'b0;
        w_drop_ready    = 1'b0;
        b_err_ready     = 1'b0;

        // Reset state
        #2;
        chk("rst_s_awready", s_axi4_awready, 0);
        chk("rst_m_awvalid", m_axi4_awvalid, 0);
        chk("rst_w_drop_valid", w_drop_valid, 0);
        chk("rst_state", state_dbg, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        cyc();
        chk("post_rst_s_awready", s_axi4_awready, 1);

        // Hit path, lookup result one cycle after LOOKUP entry
        exp_q.push_back(32'h8000_0040);
        put_aw(mk_aw(4'd3, 32'h1000_0040, 8'd7));
        chk("hit_lookup_req", lookup_req, 1);
        chk("hit_lookup_addr", lookup_addr, 32'h1000_0040);
        resolve(1'b0, 32'h8000_0040, 1);
        chk("hit_m_awvalid", m_axi4_awvalid, 1);
        chk("hit_m_awaddr", m_axi4_awaddr, 32'h8000_0040);
        chk("hit_m_awid", m_axi4_awid, 3);
        chk("hit_m_awlen", m_axi4_awlen, 7);
        chk("hit_m_awuser", m_axi4_awuser, 4'ha);
        chk("hit_b_err_valid", b_err_valid, 0);
        chk("hit_fifo_head", {w_drop_valid, w_drop}, 2'b10);
        wait_m_hs();
        drain_drops();

        // Miss path, result in the first LOOKUP cycle
        exp_b_q.push_back(4'd5);
        put_aw(mk_aw(4'd5, 32'h2000_0000, 8'd3));
        resolve(1'b1, 32'hdead_beef, 0);
        chk("miss_b_err_valid", b_err_valid, 1);
        chk("miss_b_err_id", b_err_id, 5);
        chk("miss_m_awvalid", m_axi4_awvalid, 0);
        chk("miss_fifo_head", {w_drop_valid, w_drop}, 2'b11);
        repeat (3) cyc();
        chk("miss_b_err_held", b_err_valid, 1);
        wait_b_hs();
        drain_drops();

        // Back-pressure: 10 stalled cycles with a stray lookup_done in SEND
        exp_q.push_back(32'h4000_1234);
        put_aw(mk_aw(4'd9, 32'h0000_1234, 8'd15));
        resolve(1'b0, 32'h4000_1234, 2);
        repeat (4) cyc();
        lookup_done = 1'b1;
        lookup_miss = 1'b1;
        lookup_out_addr = 32'hffff_0000;
        cyc();
        lookup_done = 1'b0;
        lookup_miss = 1'b0;
        repeat (5) cyc();
        chk("bp_m_awaddr", m_axi4_awaddr, 32'h4000_1234);
        chk("bp_s_awready", s_axi4_awready, 0);
        wait_m_hs();
        chk("bp_after_s_awready", s_axi4_awready, 1);
        drain_drops();

        // FIFO full: four hits with the W stage stalled
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(32'h9000_0000 + 32'(i) * 32'h100);
            put_aw(mk_aw(IDW'(i), 32'h3000_0000 + 32'(i) * 32'h100, 8'(i)));
            resolve(1'b0, 32'h9000_0000 + 32'(i) * 32'h100, 0);
            wait_m_hs();
        end
        s_aw = mk_aw(4'he, 32'h3000_0e00, 8'd1);
        s_axi4_awvalid = 1'b1;
        repeat (3) cyc();
        chk("full_s_awready", s_axi4_awready, 0);
        chk("full_w_drop_valid", w_drop_valid, 1);
        chk("full_lookup_req", lookup_req, 0);
        w_drop_ready = 1'b1;
        cyc();
        w_drop_ready = 1'b0;
        chk("pop_s_awready", s_axi4_awready, 1);
        cyc();
        s_axi4_awvalid = 1'b0;
        chk("resume_lookup_req", lookup_req, 1);
        // Push and pop in the same cycle
        exp_q.push_back(32'h9000_0e00);
        w_drop_ready = 1'b1;
        resolve(1'b0, 32'h9000_0e00, 0);
        w_drop_ready = 1'b0;
        wait_m_hs();
        drain_drops();

        // Reset in the middle of SEND
        put_aw(mk_aw(4'd6, 32'h5000_0000, 8'd2));
        resolve(1'b0, 32'h6000_0000, 0);
        chk("pre_rst_m_awvalid", m_axi4_awvalid, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_m_awvalid", m_axi4_awvalid, 0);
        chk("arst_b_err_valid", b_err_valid, 0);
        chk("arst_s_awready", s_axi4_awready, 0);
        chk("arst_lookup_req", lookup_req, 0);
        chk("arst_w_drop_valid", w_drop_valid, 0);
        chk("arst_m_awaddr", m_axi4_awaddr, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        cyc();
        chk("rel_w_drop_valid", w_drop_valid, 0);
        chk("rel_s_awready", s_axi4_awready, 1);

        repeat (2) cyc();
        chk("aw_sb_leftover", exp_q.size(), 0);
        chk("b_sb_leftover", exp_b_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
